vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_pix_tick.sv | 43 ++++
 rtl/vga_sync_gen.sv | 109 ++++++++++
 tb/tb_vga_sync_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and small helpers for the VGA
// sync path. Coordinates are carried as 11-bit unsigned values, so both the
// horizontal and vertical totals must stay at or below 2047.
package vga_timing_pkg;

    localparam int unsigned COORD_W    = 11;
    localparam int unsigned PRESCALE_W = 8;   // holds CLK_DIV-1 for CLK_DIV 1..255

    localparam int unsigned VGA_CLK_DIV  = 4;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [COORD_W-1:0] coord_t;

    // Half-open window test lo <= pos < hi, in coordinate width.
    function automatic logic in_span(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate prescaler. Counts 0..CLK_DIV-1 on each enabled clk and emits a
// registered one-clk pix_tick on the clk in which the count wraps. While en
// is low the count is held and pix_tick is forced low, so counting resumes
// from the held phase.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   en       count enable
//   pix_tick one-clk pulse per pixel period
module vga_pix_tick
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(CLK_DIV - 1);

    logic [PRESCALE_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            pix_tick <= 1'b0;
        end else if (en) begin
            if (count == LAST) begin
                count    <= '0;
                pix_tick <= 1'b1;
            end else begin
                count    <= count + 1'b1;
                pix_tick <= 1'b0;
            end
        end else begin
            pix_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator. A prescaler produces the pixel tick; column
// and row counters step on each tick and are driven straight out to the
// pattern stage. Visibility and sync decode is taken from the current
// counters and registered, so video_on/hsync/vsync lag col/row by one clk,
// lining up with the pattern stage's registered RGB.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   en          count enable; low freezes the raster
//   pix_tick    one-clk pulse per pixel period
//   col, row    current raster position (counter registers)
//   video_on    visible flag for the position one clk earlier
//   hsync       horizontal sync, asserted level SYNC_POL
//   vsync       vertical sync, asserted level SYNC_POL
//   frame_start one-clk pulse in the first clk at (0,0) after a frame wrap
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               pix_tick,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam coord_t H_ACT        = coord_t'(H_ACTIVE);
    localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t H_LAST       = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_ACT        = coord_t'(V_ACTIVE);
    localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam coord_t V_LAST       = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic col_last;
    logic row_last;
    logic video_d;
    logic hsync_d;
    logic vsync_d;

    vga_pix_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pix_tick (pix_tick)
    );

    assign col_last = (col == H_LAST);
    assign row_last = (row == V_LAST);

    // Counters step on pix_tick alone: a tick already issued when en drops
    // is still consumed, so a pause inserts idle clks without losing a pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_tick && col_last && row_last;
            if (pix_tick) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        video_d = (col < H_ACT) && (row < V_ACT);
        hsync_d = in_span(col, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d = in_span(row, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    end

    // Decode registers update every clk, so they keep following a frozen raster.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            video_on <= 1'b0;
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
        end else begin
            video_on <= video_d;
            hsync    <= hsync_d;
            vsync    <= vsync_d;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    // Shrunk raster so several whole frames fit in a short run.
    localparam int DIV   = 4;
    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HS    = 4;
    localparam int HBP   = 3;
    localparam int VA    = 10;
    localparam int VFP   = 2;
    localparam int VS    = 2;
    localparam int VBP   = 3;
    localparam int HT    = HA + HFP + HS + HBP;   // 25
    localparam int VT    = VA + VFP + VS + VBP;   // 17
    localparam int FRAME = HT * VT * DIV;         // 1700 clks
    localparam logic POL = 1'b0;

    typedef struct packed {
        logic               tick;
        logic [COORD_W-1:0] col;
        logic [COORD_W-1:0] row;
        logic               vid;
        logic               hs;
        logic               vs;
        logic               fs;
    } obs_t;

    localparam obs_t RST_OBS = '{tick: 1'b0, col: '0, row: '0, vid: 1'b0,
                                 hs: ~POL, vs: ~POL, fs: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic               pix_tick;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic               video_on;
    logic               hsync;
    logic               vsync;
    logic               frame_start;
    obs_t               dut_obs;

    int errors = 0;
    int checks = 0;

    // Reference model state: enabled-edge count, pixel index, tick, decode regs.
    int   m_e;
    int   m_idx;
    logic m_t;
    logic m_vid;
    logic m_hs;
    logic m_vs;
    logic m_fs;

    obs_t sb[$];

    int st_hs, st_vs, st_vid, st_fs, st_tick;
    int hs_run, hs_run_max, vs_run, vs_run_max;

    vga_sync_gen #(
        .CLK_DIV  (DIV),
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP),
        .SYNC_POL (POL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pix_tick    (pix_tick),
        .col         (col),
        .row         (row),
        .video_on    (video_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    assign dut_obs = {pix_tick, col, row, video_on, hsync, vsync, frame_start};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t exp);
        checks++;
        assert (dut_obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed tick/col/row/vid/hs/vs/fs=%0d/%0d/%0d/%0d/%0d/%0d/%0d expected=%0d/%0d/%0d/%0d/%0d/%0d/%0d",
                   tag, $time, dut_obs.tick, dut_obs.col, dut_obs.row, dut_obs.vid,
                   dut_obs.hs, dut_obs.vs, dut_obs.fs, exp.tick, exp.col, exp.row,
                   exp.vid, exp.hs, exp.vs, exp.fs);
        end
    endtask

    task automatic model_reset();
        m_e   = 0;
        m_idx = 0;
        m_t   = 1'b0;
        m_vid = 1'b0;
        m_hs  = ~POL;
        m_vs  = ~POL;
        m_fs  = 1'b0;
    endtask

    // One clk edge of the reference: decode the pre-edge position, then
    // advance the position if a tick was pending, then update the tick.
    task automatic model_edge();
        int c;
        int r;
        c     = m_idx % HT;
        r     = (m_idx / HT) % VT;
        m_vid = (c < HA) && (r < VA);
        m_hs  = (c >= HA + HFP && c < HA + HFP + HS) ? POL : ~POL;
        m_vs  = (r >= VA + VFP && r < VA + VFP + VS) ? POL : ~POL;
        m_fs  = m_t && ((m_idx % (HT * VT)) == HT * VT - 1);
        if (m_t) m_idx++;
        if (en) m_e++;
        m_t   = en && ((m_e % DIV) == 0);
    endtask

    function automatic obs_t model_obs();
        obs_t e;
        e.tick = m_t;
        e.col  = COORD_W'(m_idx % HT);
        e.row  = COORD_W'((m_idx / HT) % VT);
        e.vid  = m_vid;
        e.hs   = m_hs;
        e.vs   = m_vs;
        e.fs   = m_fs;
        return e;
    endfunction

    task automatic clear_stats();
        st_hs = 0; st_vs = 0; st_vid = 0; st_fs = 0; st_tick = 0;
        hs_run = 0; hs_run_max = 0; vs_run = 0; vs_run_max = 0;
    endtask

    task automatic step(input int n);
        obs_t exp;
        repeat (n) begin
            @(posedge clk);
            model_edge();
            sb.push_back(model_obs());
            @(negedge clk);
            exp = sb.pop_front();
            chk_obs("raster", exp);
            if (hsync === POL) begin
                st_hs++; hs_run++;
                if (hs_run > hs_run_max) hs_run_max = hs_run;
            end else hs_run = 0;
            if (vsync === POL) begin
                st_vs++; vs_run++;
                if (vs_run > vs_run_max) vs_run_max = vs_run;
            end else vs_run = 0;
            if (video_on === 1'b1)    st_vid++;
            if (frame_start === 1'b1) st_fs++;
            if (pix_tick === 1'b1)    st_tick++;
        end
    endtask

    // Runs until the model has just stepped onto pixel index tgt.
    task automatic run_to(input int tgt);
        for (int k = 0; k < 4 * FRAME && m_e != tgt * DIV + 1; k++) step(1);
    endtask

    initial begin
        int tgt;
        model_reset();
        clear_stats();

        // Reset held for 5 clks with en high.
        repeat (5) begin
            @(negedge clk);
            chk_obs("reset_hold", RST_OBS);
        end
        rst = 1'b0;

        // Three uninterrupted frames. (0,0) is shown for DIV+1 clks after
        // reset release, hence the single extra visible clk.
        clear_stats();
        step(3 * FRAME);
        chk("hsync_clks",   st_hs,      3 * VT * HS * DIV);
        chk("hsync_width",  hs_run_max, HS * DIV);
        chk("vsync_clks",   st_vs,      3 * VS * HT * DIV);
        chk("vsync_width",  vs_run_max, VS * HT * DIV);
        chk("video_clks",   st_vid,     3 * HA * VA * DIV + 1);
        chk("frame_starts", st_fs,      2);

        // Pause 20 clks mid-line at row 3, col 12.
        tgt = (m_idx / (HT * VT) + 1) * HT * VT + 3 * HT + 12;
        run_to(tgt);
        en = 1'b0;
        clear_stats();
        step(20);
        chk("freeze_col",   int'(col), 12);
        chk("freeze_row",   int'(row), 3);
        chk("freeze_ticks", st_tick,   0);
        en = 1'b1;
        clear_stats();
        step(FRAME);
        chk("resume_frame_starts", st_fs, 1);

        // Async reset between edges at row 5, col 10.
        tgt = (m_idx / (HT * VT) + 1) * HT * VT + 5 * HT + 10;
        run_to(tgt);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_obs("async_reset", RST_OBS);
        model_reset();
        @(negedge clk);
        chk_obs("reset_hold2", RST_OBS);
        rst = 1'b0;
        clear_stats();
        step(2 * FRAME);
        chk("restart_frame_starts", st_fs, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
